// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle control unit for the MIPS-subset CPU. Steps one instruction
//   through FETCH / DECODE / EXEC / MEMADDR / MEMRD / MEMWR / WBALU / WBMEM /
//   BRANCH / JUMP and drives every datapath select and strobe.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous, active-high; forces FETCH, zeroes all outputs
//   Op[5:0]    in   IR[31:26]
//   Funct[5:0] in   IR[5:0]
//   Zero       in   ALU zero flag (combinational, used in BRANCH)
//   MemReady   in   memory completes the current access this cycle
//   PCWrite, IRWrite, MemRead, MemWrite, RegWrite   out  strobes
//   IorD       out  memory address: 0 = PC, 1 = ALUOut
//   RegDst     out  0 = rt, 1 = rd
//   MemToReg   out  0 = ALUOut, 1 = MDR
//   SignExt    out  1 = sign-extend immediate, 0 = zero-extend
//   ALUSrcA    out  0 = PC, 1 = rs
//   ALUSrcB    out  00 rt, 01 const 4, 10 ExtImm, 11 ExtImm<<2
//   ALUOp      out  000 add, 001 sub, 010 and, 011 or, 100 slt
//   PCSrc      out  00 ALU result, 01 ALUOut, 10 jump target
//   State      out  current state code (debug)
//   IllegalOp  out  one-cycle pulse on unsupported opcode or funct
module multicycle_ctrl (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       SignExt,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [3:0] State,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC    = 4'd2,
        MEMADDR = 4'd3,
        MEMRD   = 4'd4,
        MEMWR   = 4'd5,
        WBALU   = 4'd6,
        WBMEM   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // Returns {valid, alu_op} for an R-type funct field.
    function automatic logic [3:0] funct_decode(input logic [5:0] f);
        case (f)
            6'b100000: funct_decode = {1'b1, ALU_ADD};
            6'b100010: funct_decode = {1'b1, ALU_SUB};
            6'b100100: funct_decode = {1'b1, ALU_AND};
            6'b100101: funct_decode = {1'b1, ALU_OR};
            6'b101010: funct_decode = {1'b1, ALU_SLT};
            default:   funct_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

    state_t     state;
    state_t     next_state;
    logic [3:0] rtype_dec;

    assign rtype_dec = funct_decode(Funct);
    assign State     = state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        SignExt    = 1'b1;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = ALU_ADD;
        PCSrc      = 2'b00;
        IllegalOp  = 1'b0;

        case (state)
            FETCH: begin
                // PC+4 is computed every FETCH cycle; PC/IR only commit once
                // the memory has returned the instruction.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                // Speculative branch target: PC + (SignExt(imm) << 2).
                ALUSrcB = 2'b11;
                case (Op)
                    OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI: next_state = EXEC;
                    OP_LW, OP_SW:                       next_state = MEMADDR;
                    OP_BEQ:                             next_state = BRANCH;
                    OP_J:                               next_state = JUMP;
                    default: begin
                        IllegalOp  = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                next_state = WBALU;
                case (Op)
                    OP_RTYPE: begin
                        ALUSrcB = 2'b00;
                        ALUOp   = rtype_dec[2:0];
                        if (!rtype_dec[3]) begin
                            IllegalOp  = 1'b1;
                            next_state = FETCH;
                        end
                    end
                    OP_ADDI: begin
                        ALUSrcB = 2'b10;
                        ALUOp   = ALU_ADD;
                    end
                    OP_ANDI: begin
                        ALUSrcB = 2'b10;
                        ALUOp   = ALU_AND;
                        SignExt = 1'b0;
                    end
                    OP_ORI: begin
                        ALUSrcB = 2'b10;
                        ALUOp   = ALU_OR;
                        SignExt = 1'b0;
                    end
                    default: ;
                endcase
            end
            WBALU: begin
                RegWrite   = 1'b1;
                RegDst     = (Op == OP_RTYPE);
                next_state = FETCH;
            end
            MEMADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) next_state = WBMEM;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) next_state = FETCH;
            end
            WBMEM: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b00;
                ALUOp      = ALU_SUB;
                PCSrc      = 2'b01;
                PCWrite    = Zero;
                next_state = FETCH;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase

        // Outputs are gated combinationally so an in-flight memory write
        // drops in the same cycle Reset rises, without waiting for a clock.
        if (Reset) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IorD      = 1'b0;
            RegDst    = 1'b0;
            MemToReg  = 1'b0;
            SignExt   = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            ALUOp     = ALU_ADD;
            PCSrc     = 2'b00;
            IllegalOp = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: table-driven instruction vectors, hand
// sequences for reset, and randomized instructions against a reference model
// that expands each instruction into its list of phases.
module tb_multicycle_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [5:0] Op, Funct;
    logic       Zero, MemReady;
    logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD, RegDst;
    logic       MemToReg, SignExt, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] State;

    multicycle_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IorD(IorD), .RegDst(RegDst), .MemToReg(MemToReg), .SignExt(SignExt),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .State(State), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] state;
        logic       pcw, irw, mrd, mwr, rgw, iord, rdst, m2r, sext, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       ill;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         wf;     // MemReady=0 cycles in FETCH
        int         wm;     // MemReady=0 cycles in MEMRD/MEMWR
        int         lat;    // expected cycles FETCH..last state
        string      name;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic out_t dut_out();
        out_t o;
        o.state = State;  o.pcw = PCWrite;  o.irw = IRWrite;  o.mrd = MemRead;
        o.mwr = MemWrite; o.rgw = RegWrite; o.iord = IorD;    o.rdst = RegDst;
        o.m2r = MemToReg; o.sext = SignExt; o.srca = ALUSrcA; o.srcb = ALUSrcB;
        o.aluop = ALUOp;  o.pcsrc = PCSrc;  o.ill = IllegalOp;
        return o;
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'd0, 6'd8, 6'd12, 6'd13, 6'd35, 6'd43, 6'd4, 6'd2};
    endfunction

    function automatic bit legal_funct(input logic [5:0] f);
        return f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'd34:   return 3'd1;
            6'd36:   return 3'd2;
            6'd37:   return 3'd3;
            6'd42:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Expected outputs for one cycle spent in phase st.
    function automatic out_t model_out(input int st, input logic [5:0] op,
                                       input logic [5:0] funct,
                                       input logic zero, input logic mr);
        out_t o = '0;
        o.state = st[3:0];
        o.sext  = 1'b1;
        case (st)
            0: begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
            1: begin o.srcb = 2'b11; o.ill = !legal_op(op); end
            2: begin
                o.srca = 1;
                if (op == 6'd0) begin
                    o.aluop = funct_alu(funct);
                    o.ill   = !legal_funct(funct);
                end else begin
                    o.srcb = 2'b10;
                    if (op == 6'd12) begin o.aluop = 3'd2; o.sext = 0; end
                    if (op == 6'd13) begin o.aluop = 3'd3; o.sext = 0; end
                end
            end
            3: begin o.srca = 1; o.srcb = 2'b10; end
            4: begin o.mrd = 1; o.iord = 1; end
            5: begin o.mwr = 1; o.iord = 1; end
            6: begin o.rgw = 1; o.rdst = (op == 6'd0); end
            7: begin o.rgw = 1; o.m2r = 1; end
            8: begin o.srca = 1; o.aluop = 3'd1; o.pcsrc = 2'b01; o.pcw = zero; end
            9: begin o.pcsrc = 2'b10; o.pcw = 1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check_out(input out_t exp, input string name, input int cyc);
        out_t act = dut_out();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 in FETCH.
    task automatic run_instr(input vec_t v);
        int   ph[$];
        out_t q[$];
        logic mq[$];
        int   nonzero = 0;
        ph.push_back(0);
        ph.push_back(1);
        case (v.op)
            6'd0: begin ph.push_back(2); if (legal_funct(v.funct)) ph.push_back(6); end
            6'd8, 6'd12, 6'd13: begin ph.push_back(2); ph.push_back(6); end
            6'd35: begin ph.push_back(3); ph.push_back(4); ph.push_back(7); end
            6'd43: begin ph.push_back(3); ph.push_back(5); end
            6'd4:  ph.push_back(8);
            6'd2:  ph.push_back(9);
            default: ;
        endcase
        foreach (ph[k]) begin
            int  st = ph[k];
            if (st == 0 || st == 4 || st == 5) begin
                int w = (st == 0) ? v.wf : v.wm;
                for (int i = 0; i < w; i++) begin
                    q.push_back(model_out(st, v.op, v.funct, v.zero, 1'b0));
                    mq.push_back(1'b0);
                end
                q.push_back(model_out(st, v.op, v.funct, v.zero, 1'b1));
                mq.push_back(1'b1);
            end else begin
                logic r = 1'($urandom_range(0, 1));
                q.push_back(model_out(st, v.op, v.funct, v.zero, r));
                mq.push_back(r);
            end
        end
        Op = v.op; Funct = v.funct; Zero = v.zero;
        foreach (q[i]) begin
            MemReady = mq[i];
            @(negedge Clk);
            check_out(q[i], v.name, i);
            if (State != 4'd0) nonzero++;
            @(posedge Clk);
            #1;
        end
        // Back in FETCH, held there by MemReady=0.
        MemReady = 1'b0;
        @(negedge Clk);
        check_out(model_out(0, v.op, v.funct, v.zero, 1'b0), {v.name, " end"}, q.size());
        if (v.lat >= 0)
            check_val({v.name, " latency"}, v.wf + 1 + nonzero, v.lat);
        @(posedge Clk);
        #1;
    endtask

    vec_t vecs[$];
    logic [5:0] op_pool[12] = '{6'd0, 6'd0, 6'd8, 6'd12, 6'd13, 6'd35, 6'd43,
                                6'd4, 6'd2, 6'd63, 6'd1, 6'd16};
    logic [5:0] fn_pool[7]  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd7, 6'd0};

    initial begin
        vecs.push_back('{6'd8,  6'd0,  1'b0, 0, 0, 4, "addi"});
        vecs.push_back('{6'd13, 6'd0,  1'b0, 0, 0, 4, "ori"});
        vecs.push_back('{6'd12, 6'd0,  1'b1, 0, 0, 4, "andi"});
        vecs.push_back('{6'd0,  6'd32, 1'b0, 0, 0, 4, "add"});
        vecs.push_back('{6'd0,  6'd34, 1'b0, 0, 0, 4, "sub"});
        vecs.push_back('{6'd0,  6'd36, 1'b0, 0, 0, 4, "and"});
        vecs.push_back('{6'd0,  6'd37, 1'b0, 0, 0, 4, "or"});
        vecs.push_back('{6'd0,  6'd42, 1'b0, 2, 0, 6, "slt wait2"});
        vecs.push_back('{6'd35, 6'd0,  1'b0, 0, 0, 5, "lw"});
        vecs.push_back('{6'd35, 6'd0,  1'b0, 0, 2, 7, "lw wait2"});
        vecs.push_back('{6'd43, 6'd0,  1'b0, 0, 0, 4, "sw"});
        vecs.push_back('{6'd43, 6'd0,  1'b1, 1, 1, 6, "sw wait"});
        vecs.push_back('{6'd4,  6'd0,  1'b1, 0, 0, 3, "beq taken"});
        vecs.push_back('{6'd4,  6'd0,  1'b0, 0, 0, 3, "beq not"});
        vecs.push_back('{6'd2,  6'd0,  1'b0, 0, 0, 3, "j"});
        vecs.push_back('{6'd63, 6'd0,  1'b0, 0, 0, 2, "illegal op"});
        vecs.push_back('{6'd0,  6'd7,  1'b0, 0, 0, 3, "illegal funct"});

        Reset = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_out('0, "reset outputs", 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        MemReady = 1'b0;
        @(negedge Clk);
        check_out(model_out(0, 6'd0, 6'd0, 1'b0, 1'b0), "first fetch", 0);
        @(posedge Clk);
        #1;

        foreach (vecs[i]) run_instr(vecs[i]);

        // Reset asserted while a store waits in MEMWR.
        Op = 6'd43; Funct = '0; MemReady = 1'b1;
        @(posedge Clk); #1;                 // -> DECODE
        @(posedge Clk); #1;                 // -> MEMADDR
        MemReady = 1'b0;
        @(posedge Clk); #1;                 // -> MEMWR
        @(negedge Clk);
        check_val("memwr state", State, 5);
        check_val("memwr strobe", MemWrite, 1);
        #1 Reset = 1'b1;
        #1;
        check_out('0, "async reset mid-memwr", 0);
        @(posedge Clk);
        #1;
        check_out('0, "reset held", 0);
        Reset = 1'b0;
        @(negedge Clk);
        check_out(model_out(0, 6'd43, 6'd0, 1'b0, 1'b0), "fetch after reset", 0);
        @(posedge Clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            vec_t v;
            v.op    = op_pool[$urandom_range(0, 11)];
            v.funct = fn_pool[$urandom_range(0, 6)];
            v.zero  = 1'($urandom_range(0, 1));
            v.wf    = $urandom_range(0, 2);
            v.wm    = $urandom_range(0, 2);
            v.lat   = -1;
            v.name  = $sformatf("rand%0d op%0d fn%0d", n, v.op, v.funct);
            run_instr(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
